// File: rtl/tmds_mono_encoder.sv
// Maps a 1-bit pixel to a fg/bg RGB888 colour and TMDS-encodes it into three
// DVI 10-bit symbols (ch0=blue+sync, ch1=green, ch2=red), two pclk of latency.
module tmds_mono_encoder #(
   parameter logic [7:0] FG_R = 8'hFF,
   parameter logic [7:0] FG_G = 8'hFF,
   parameter logic [7:0] FG_B = 8'hFF,
   parameter logic [7:0] BG_R = 8'h00,
   parameter logic [7:0] BG_G = 8'h00,
   parameter logic [7:0] BG_B = 8'h00
) (
   input  logic       pclk,
   input  logic       reset_n,
   input  logic       hs,
   input  logic       vs,
   input  logic       pixel_i,
   input  logic       blank,
   output logic [9:0] tmds_ch0,
   output logic [9:0] tmds_ch1,
   output logic [9:0] tmds_ch2
);

   localparam logic [9:0] TOKEN_00 = 10'h354;
   localparam logic [9:0] TOKEN_01 = 10'h0AB;
   localparam logic [9:0] TOKEN_10 = 10'h154;
   localparam logic [9:0] TOKEN_11 = 10'h2AB;

   function automatic logic [3:0] ones8(input logic [7:0] d);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
      return n;
   endfunction

   // Transition minimisation: XNOR chain when the byte is ones-heavy, XOR otherwise.
   function automatic logic [8:0] minimise(input logic [7:0] d);
      logic [8:0] q;
      logic [3:0] n;
      logic       use_xnor;
      n        = ones8(d);
      use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
      q        = '0;
      q[0]     = d[0];
      for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8]     = ~use_xnor;
      return q;
   endfunction

   logic [7:0] colour [3];
   logic [9:0] sym_out [3];

   always_comb begin
      colour[0] = pixel_i ? FG_B : BG_B;
      colour[1] = pixel_i ? FG_G : BG_G;
      colour[2] = pixel_i ? FG_R : BG_R;
   end

   logic hs_reg;
   logic vs_reg;
   logic blank_reg;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         hs_reg    <= 1'b0;
         vs_reg    <= 1'b0;
         blank_reg <= 1'b1;
      end else begin
         hs_reg    <= hs;
         vs_reg    <= vs;
         blank_reg <= blank;
      end
   end

   logic [9:0] token0;
   always_comb begin
      case ({vs_reg, hs_reg})
         2'b00:   token0 = TOKEN_00;
         2'b01:   token0 = TOKEN_01;
         2'b10:   token0 = TOKEN_10;
         default: token0 = TOKEN_11;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ch
         logic [8:0]        q_m_next;
         logic [8:0]        q_m_reg;
         logic [3:0]        n1_reg;
         logic [9:0]        sym_reg;
         logic [9:0]        sym_next;
         logic [9:0]        ctrl_sym;
         logic signed [4:0] cnt_reg;
         logic signed [4:0] cnt_next;
         logic signed [5:0] diff;
         logic signed [5:0] cnt_ext;
         logic signed [5:0] acc;
         logic              q8;

         assign q_m_next = minimise(colour[gi]);
         assign ctrl_sym = (gi == 0) ? token0 : TOKEN_00;

         // n1 of q_m[7:0] is computed in stage 1 to shorten the balance path.
         always_ff @(posedge pclk or negedge reset_n) begin
            if (!reset_n) begin
               q_m_reg <= '0;
               n1_reg  <= '0;
            end else begin
               q_m_reg <= q_m_next;
               n1_reg  <= ones8(q_m_next[7:0]);
            end
         end

         always_comb begin
            q8       = q_m_reg[8];
            diff     = $signed({1'b0, n1_reg, 1'b0}) - 6'sd8;
            cnt_ext  = $signed({cnt_reg[4], cnt_reg});
            sym_next = {1'b0, q8, q_m_reg[7:0]};
            acc      = cnt_ext;
            if (blank_reg) begin
               sym_next = ctrl_sym;
               acc      = '0;
            end else if ((cnt_reg == 5'sd0) || (n1_reg == 4'd4)) begin
               sym_next = {~q8, q8, q8 ? q_m_reg[7:0] : ~q_m_reg[7:0]};
               acc      = q8 ? (cnt_ext + diff) : (cnt_ext - diff);
            end else if ((!cnt_reg[4] && (n1_reg > 4'd4)) || (cnt_reg[4] && (n1_reg < 4'd4))) begin
               sym_next = {1'b1, q8, ~q_m_reg[7:0]};
               acc      = cnt_ext - diff + (q8 ? 6'sd2 : 6'sd0);
            end else begin
               sym_next = {1'b0, q8, q_m_reg[7:0]};
               acc      = cnt_ext + diff - (q8 ? 6'sd0 : 6'sd2);
            end
            cnt_next = acc[4:0];
         end

         always_ff @(posedge pclk or negedge reset_n) begin
            if (!reset_n) begin
               sym_reg <= TOKEN_00;
               cnt_reg <= '0;
            end else begin
               sym_reg <= sym_next;
               cnt_reg <= cnt_next;
            end
         end

         assign sym_out[gi] = sym_reg;
      end
   endgenerate

   assign tmds_ch0 = sym_out[0];
   assign tmds_ch1 = sym_out[1];
   assign tmds_ch2 = sym_out[2];

endmodule

// File: tb/tb_tmds_mono_encoder.sv
// Directed and random-frame bench for tmds_mono_encoder; a second instance with
// FG_R=8'h10 is checked by decoding its symbols back to colour bytes.
module tb_tmds_mono_encoder;

   logic       pclk = 1'b0;
   logic       reset_n;
   logic       hs, vs, pixel_i, blank;
   logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;
   logic [9:0] r10_ch0, r10_ch1, r10_ch2;

   int checks   = 0;
   int failures = 0;
   int model_cnt [3];

   typedef struct packed {
      logic       v;
      logic       video;
      logic       pix;
      logic [9:0] c0;
      logic [9:0] c1;
      logic [9:0] c2;
   } exp_t;

   exp_t pend [$];

   always #5 pclk = ~pclk;

   tmds_mono_encoder dut (
      .pclk(pclk), .reset_n(reset_n), .hs(hs), .vs(vs), .pixel_i(pixel_i), .blank(blank),
      .tmds_ch0(tmds_ch0), .tmds_ch1(tmds_ch1), .tmds_ch2(tmds_ch2)
   );

   tmds_mono_encoder #(.FG_R(8'h10)) dut_r10 (
      .pclk(pclk), .reset_n(reset_n), .hs(hs), .vs(vs), .pixel_i(pixel_i), .blank(blank),
      .tmds_ch0(r10_ch0), .tmds_ch1(r10_ch1), .tmds_ch2(r10_ch2)
   );

   task automatic check10(input string tag, input logic [9:0] obs, input logic [9:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [9:0] token(input logic v, input logic h);
      case ({v, h})
         2'b00:   return 10'h354;
         2'b01:   return 10'h0AB;
         2'b10:   return 10'h154;
         default: return 10'h2AB;
      endcase
   endfunction

   function automatic logic [7:0] tmds_dec(input logic [9:0] s);
      logic [7:0] q;
      logic [7:0] d;
      q    = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   // Reference encoder written straight from the DVI equations, integer disparity.
   function automatic logic [9:0] tmds_ref(input logic [7:0] d, input int ch);
      int         n1d, n1, n0;
      logic       xn;
      logic [8:0] qm;
      logic [9:0] r;
      n1d   = $countones(d);
      xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~xn;
      n1    = $countones(qm[7:0]);
      n0    = 8 - n1;
      if (model_cnt[ch] == 0 || n1 == n0) begin
         if (qm[8]) begin
            r = {2'b01, qm[7:0]};
            model_cnt[ch] += n1 - n0;
         end else begin
            r = {2'b10, ~qm[7:0]};
            model_cnt[ch] += n0 - n1;
         end
      end else if ((model_cnt[ch] > 0 && n1 > n0) || (model_cnt[ch] < 0 && n0 > n1)) begin
         r = {1'b1, qm[8], ~qm[7:0]};
         model_cnt[ch] += (qm[8] ? 2 : 0) + n0 - n1;
      end else begin
         r = {1'b0, qm[8], qm[7:0]};
         model_cnt[ch] += n1 - n0 - (qm[8] ? 0 : 2);
      end
      return r;
   endfunction

   task automatic step(input logic b, input logic v, input logic h, input logic p,
                       input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2,
                       input string tag, input bit verbose);
      exp_t e;
      exp_t x;
      blank   = b;
      vs      = v;
      hs      = h;
      pixel_i = p;
      if (b) for (int c = 0; c < 3; c++) model_cnt[c] = 0;
      e = '{v: 1'b1, video: ~b, pix: p, c0: e0, c1: e1, c2: e2};
      pend.push_back(e);
      @(posedge pclk);
      #1;
      if (verbose)
         $display("%s: in blank=%0d vs=%0d hs=%0d pix=%0d | out ch0=%h ch1=%h ch2=%h",
                  tag, b, v, h, p, tmds_ch0, tmds_ch1, tmds_ch2);
      if (pend.size() == 2) begin
         x = pend.pop_front();
         if (x.v) begin
            check10({tag, " ch0"}, tmds_ch0, x.c0);
            check10({tag, " ch1"}, tmds_ch1, x.c1);
            check10({tag, " ch2"}, tmds_ch2, x.c2);
            if (x.video) begin
               check8({tag, " r10 dec ch2"}, tmds_dec(r10_ch2), x.pix ? 8'h10 : 8'h00);
               check8({tag, " r10 dec ch1"}, tmds_dec(r10_ch1), x.pix ? 8'hFF : 8'h00);
               check8({tag, " r10 dec ch0"}, tmds_dec(r10_ch0), x.pix ? 8'hFF : 8'h00);
            end else begin
               check10({tag, " r10 ch0"}, r10_ch0, x.c0);
               check10({tag, " r10 ch2"}, r10_ch2, x.c2);
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check10({tag, " ch0"}, tmds_ch0, 10'h354);
      check10({tag, " ch1"}, tmds_ch1, 10'h354);
      check10({tag, " ch2"}, tmds_ch2, 10'h354);
      check10({tag, " r10 ch2"}, r10_ch2, 10'h354);
   endtask

   initial begin
      logic       b, v, h, p;
      logic [7:0] d;
      logic [9:0] e0, e1, e2;

      // Power-on reset with blank inputs.
      reset_n = 1'b0;
      blank = 1'b1; vs = 1'b0; hs = 1'b0; pixel_i = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      pend.delete();
      pend.push_back('{v: 1'b1, video: 1'b0, pix: 1'b0, c0: 10'h354, c1: 10'h354, c2: 10'h354});

      // Control tokens from {vs,hs}.
      step(1, 0, 0, 0, 10'h354, 10'h354, 10'h354, "ctrl00", 1);
      step(1, 0, 1, 0, 10'h0AB, 10'h354, 10'h354, "ctrl01", 1);
      step(1, 1, 0, 0, 10'h154, 10'h354, 10'h354, "ctrl10", 1);
      step(1, 1, 1, 0, 10'h2AB, 10'h354, 10'h354, "ctrl11", 1);
      step(1, 0, 0, 0, 10'h354, 10'h354, 10'h354, "ctrl00b", 1);

      // Foreground run after blank; hs/vs toggling in video must not matter.
      step(0, 1, 1, 1, 10'h200, 10'h200, 10'h200, "fg0", 1);
      step(0, 0, 1, 1, 10'h0FF, 10'h0FF, 10'h0FF, "fg1", 1);
      step(1, 1, 0, 0, 10'h154, 10'h354, 10'h354, "fg_end", 1);

      // Background run after blank: disparity -8, +2, -6.
      step(0, 0, 0, 0, 10'h100, 10'h100, 10'h100, "bg0", 1);
      step(0, 1, 0, 0, 10'h3FF, 10'h3FF, 10'h3FF, "bg1", 1);
      step(0, 0, 1, 0, 10'h100, 10'h100, 10'h100, "bg2", 1);
      step(1, 0, 0, 0, 10'h354, 10'h354, 10'h354, "bg_end", 1);

      // Reset asserted in the middle of video.
      step(0, 0, 0, 1, 10'h200, 10'h200, 10'h200, "mid0", 1);
      step(0, 0, 0, 1, 10'h0FF, 10'h0FF, 10'h0FF, "mid1", 1);
      #2;
      reset_n = 1'b0;
      blank = 1'b1; vs = 1'b0; hs = 1'b0; pixel_i = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(posedge pclk);
      #1;
      reset_n = 1'b1;
      pend.delete();
      pend.push_back('{v: 1'b1, video: 1'b0, pix: 1'b0, c0: 10'h354, c1: 10'h354, c2: 10'h354});
      step(1, 0, 0, 0, 10'h354, 10'h354, 10'h354, "post_rst0", 1);
      step(1, 0, 0, 0, 10'h354, 10'h354, 10'h354, "post_rst1", 1);
      // First video after release appears two clocks later with fresh disparity.
      step(0, 0, 0, 1, 10'h200, 10'h200, 10'h200, "post_rst_fg", 1);
      step(1, 0, 0, 0, 10'h354, 10'h354, 10'h354, "post_rst2", 1);

      // Random lines: 640 video + 160 blank, checked against the reference model.
      for (int ln = 0; ln < 8; ln++) begin
         for (int x = 0; x < 800; x++) begin
            b = (x >= 640);
            p = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            h = 1'($urandom_range(0, 1));
            if (b) begin
               e0 = token(v, h);
               e1 = 10'h354;
               e2 = 10'h354;
            end else begin
               d  = p ? 8'hFF : 8'h00;
               e0 = tmds_ref(d, 0);
               e1 = tmds_ref(d, 1);
               e2 = tmds_ref(d, 2);
            end
            step(b, v, h, p, e0, e1, e2, $sformatf("line%0d", ln), x == 0);
         end
      end
      step(1, 0, 0, 0, 10'h354, 10'h354, 10'h354, "flush", 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
